// File: rtl/topk_conn_sorter_if.sv
// Stream bundle between the distance stage, the top-K sorter and the circuit-merging stage.
// conn is packed as {distance, pointa, pointb}.
interface topk_conn_sorter_if #(
    parameter int CONN_W = 64,
    parameter int CNT_W  = 10
);
    logic [CONN_W-1:0] conn;
    logic              conn_vld;
    logic              done;
    logic [CONN_W-1:0] out_conn;
    logic              out_vld;
    logic              out_rdy;
    logic [CNT_W-1:0]  out_rank;
    logic              out_last;

    modport slave (
        input  conn, conn_vld, done, out_rdy,
        output out_conn, out_vld, out_rank, out_last
    );

    modport master (
        output conn, conn_vld, done, out_rdy,
        input  out_conn, out_vld, out_rank, out_last
    );
endinterface

// File: rtl/topk_conn_sorter.sv
// Keeps the K smallest-distance connections in a sorted shift array, then drains them in order.
// Optional macro TOPK_DROP_CNT_EN adds drop_cnt and max_kept outputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FILL    | accepting candidates, parallel sorted insertion
// FLUSH   | one extra cycle to absorb the upstream registered valid
// DRAIN   | presenting slot 0 downstream, shift toward slot 0 on accept
// FIN     | drain complete, sort_done held until rst
module topk_conn_sorter #(
    parameter int K      = 1000,
    parameter int DIST_W = 32,
    parameter int PT_W   = 16,
    parameter int CNT_W  = $clog2(K + 1)
) (
    input  logic clk,
    input  logic rst,
    topk_conn_sorter_if.slave bus,
    output logic sort_done,
    output logic err_late
`ifdef TOPK_DROP_CNT_EN
    ,
    output logic [31:0]       drop_cnt,
    output logic [DIST_W-1:0] max_kept
`endif
);
    localparam int CONN_W = DIST_W + 2 * PT_W;

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]        state;
    logic [CONN_W-1:0] slot [K];
    logic [K-1:0]      slot_vld;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W-1:0]  rank;
    logic [DIST_W-1:0] new_dist;
    logic [K-1:0]      ins_lt;
    logic [K-1:0]      ins_prev;
    logic              accept_in;
    logic              shift_out;
    logic              last;

    assign new_dist = bus.conn[CONN_W-1 -: DIST_W];

    // ins_lt is thermometer-coded because occupied slots are sorted and contiguous
    always_comb begin
        ins_lt = '0;
        for (int i = 0; i < K; i++)
            ins_lt[i] = !slot_vld[i] || (slot[i][CONN_W-1 -: DIST_W] > new_dist);
    end
    assign ins_prev = {ins_lt[K-2:0], 1'b0};

    assign accept_in    = bus.conn_vld && (state == S_FILL || state == S_FLUSH);
    assign bus.out_vld  = (state == S_DRAIN) && slot_vld[0];
    assign bus.out_conn = slot[0];
    assign bus.out_rank = rank;
    assign last         = bus.out_vld && !slot_vld[1];
    assign bus.out_last = last;
    assign shift_out    = bus.out_vld && bus.out_rdy;
    assign sort_done    = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
        end else if (accept_in && |ins_lt) begin
            slot_vld <= {slot_vld[K-2:0], 1'b1};
            if (ins_lt[0]) slot[0] <= bus.conn;
            for (int i = 1; i < K; i++) begin
                if (ins_lt[i]) slot[i] <= ins_prev[i] ? slot[i-1] : bus.conn;
            end
        end else if (shift_out) begin
            slot_vld <= {1'b0, slot_vld[K-1:1]};
            for (int i = 0; i < K - 1; i++) slot[i] <= slot[i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FILL;
            occ      <= '0;
            rank     <= '0;
            err_late <= 1'b0;
        end else begin
            if (accept_in && |ins_lt && occ != CNT_W'(K)) occ <= occ + 1'b1;
            else if (shift_out) occ <= occ - 1'b1;

            if (shift_out && !last) rank <= rank + 1'b1;
            if (bus.conn_vld && state[1]) err_late <= 1'b1;

            case (state)
                S_FILL:  if (bus.done) state <= S_FLUSH;
                S_FLUSH: state <= S_DRAIN;
                S_DRAIN: if (occ == '0 || (shift_out && last)) state <= S_FIN;
                default: state <= S_FIN;
            endcase
        end
    end

`ifdef TOPK_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) drop_cnt <= '0;
        else if (accept_in && slot_vld[K-1] && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
    assign max_kept = slot_vld[K-1] ? slot[K-1][CONN_W-1 -: DIST_W] : '0;
`endif
endmodule

// File: tb/tb_topk_conn_sorter.sv
// Self-checking bench for topk_conn_sorter (K=4) against a sorted-queue reference model.
module tb_topk_conn_sorter;
    localparam int K      = 4;
    localparam int DIST_W = 16;
    localparam int PT_W   = 8;
    localparam int CONN_W = DIST_W + 2 * PT_W;
    localparam int CNT_W  = $clog2(K + 1);

    logic clk = 1'b0;
    logic rst;
    logic sort_done, err_late;
`ifdef TOPK_DROP_CNT_EN
    logic [31:0]       drop_cnt;
    logic [DIST_W-1:0] max_kept;
`endif

    always #5 clk = ~clk;

    topk_conn_sorter_if #(.CONN_W(CONN_W), .CNT_W(CNT_W)) bus ();

    topk_conn_sorter #(.K(K), .DIST_W(DIST_W), .PT_W(PT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sort_done (sort_done),
        .err_late  (err_late)
`ifdef TOPK_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt),
        .max_kept  (max_kept)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [CONN_W-1:0] mq[$];
    int m_drops;

    function automatic logic [CONN_W-1:0] mk(input int d, input int a, input int b);
        logic [DIST_W-1:0] dd;
        logic [PT_W-1:0]   aa, bb;
        dd = DIST_W'(d);
        aa = PT_W'(a);
        bb = PT_W'(b);
        return {dd, aa, bb};
    endfunction

    function automatic int dist_of(input logic [CONN_W-1:0] c);
        return int'(c[CONN_W-1 -: DIST_W]);
    endfunction

    // Reference: stable sorted list truncated to the K smallest
    task automatic model_ins(input logic [CONN_W-1:0] c);
        int p;
        p = mq.size();
        for (int i = mq.size() - 1; i >= 0; i--)
            if (dist_of(mq[i]) > dist_of(c)) p = i;
        mq.insert(p, c);
        if (mq.size() > K) begin
            void'(mq.pop_back());
            m_drops++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.conn_vld = 1'b0;
        bus.conn = '0;
        bus.done = 1'b0;
        bus.out_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        m_drops = 0;
    endtask

    task automatic send(input logic [CONN_W-1:0] c);
        bus.conn = c;
        bus.conn_vld = 1'b1;
        @(posedge clk); #1;
        bus.conn_vld = 1'b0;
        model_ins(c);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.out_vld !== 1'b0 || bus.out_last !== 1'b0 || sort_done !== 1'b0 ||
            err_late !== 1'b0 || bus.out_rank !== '0) begin
            n_err++;
            $display("FAIL reset: vld=%b last=%b done=%b err=%b rank=%0d, want all 0",
                     bus.out_vld, bus.out_last, sort_done, err_late, bus.out_rank);
        end
    endtask

    task automatic test_empty();
        do_reset();
        bus.done = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_vld !== 1'b0 || sort_done !== (c == 3)) begin
                n_err++;
                $display("FAIL empty cycle %0d: vld=%b sort_done=%b, want vld=0 sort_done=%b",
                         c, bus.out_vld, sort_done, c == 3);
            end
        end
    endtask

    task automatic test_sorted();
        int sc_d[3][6] = '{'{50, 10, 30, 0, 0, 0}, '{9, 7, 5, 3, 1, 8}, '{20, 20, 0, 0, 0, 0}};
        int sc_n[3] = '{3, 6, 2};
        int idx;
        for (int s = 0; s < 3; s++) begin
            do_reset();
            for (int i = 0; i < sc_n[s]; i++) send(mk(sc_d[s][i], 2 * i + 1, 2 * i + 2));
            bus.done = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
`ifdef TOPK_DROP_CNT_EN
            n_cmp++;
            if (drop_cnt !== 32'(m_drops) ||
                max_kept !== DIST_W'(mq.size() == K ? dist_of(mq[K-1]) : 0)) begin
                n_err++;
                $display("FAIL sorted%0d drop: drop_cnt=%0d max_kept=%0d, want %0d/%0d", s,
                         drop_cnt, max_kept, m_drops, mq.size() == K ? dist_of(mq[K-1]) : 0);
            end
`endif
            bus.out_rdy = 1'b1;
            idx = 0;
            while (mq.size() > 0) begin
                n_cmp++;
                if (bus.out_vld !== 1'b1 || bus.out_conn !== mq[0] ||
                    bus.out_rank !== CNT_W'(idx) || bus.out_last !== (mq.size() == 1)) begin
                    n_err++;
                    $display("FAIL sorted%0d out%0d: vld=%b conn=%h rank=%0d last=%b, want 1/%h/%0d/%b",
                             s, idx, bus.out_vld, bus.out_conn, bus.out_rank, bus.out_last,
                             mq[0], idx, mq.size() == 1);
                end
                @(posedge clk); #1;
                void'(mq.pop_front());
                idx++;
            end
            bus.out_rdy = 1'b0;
            n_cmp++;
            if (sort_done !== 1'b1 || bus.out_vld !== 1'b0) begin
                n_err++;
                $display("FAIL sorted%0d end: sort_done=%b vld=%b, want 1/0", s, sort_done, bus.out_vld);
            end
        end
    endtask

    task automatic test_late_stall_reset();
        do_reset();
        bus.conn = mk(2, 5, 6);
        bus.conn_vld = 1'b1;
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.conn = mk(1, 7, 8);
        @(posedge clk); #1;
        bus.conn_vld = 1'b0;
        n_cmp++;
        if (bus.out_vld !== 1'b1 || bus.out_conn !== mk(1, 7, 8) || err_late !== 1'b0) begin
            n_err++;
            $display("FAIL late head: vld=%b conn=%h err=%b, want 1/%h/0",
                     bus.out_vld, bus.out_conn, err_late, mk(1, 7, 8));
        end
        bus.conn = mk(0, 9, 9);
        bus.conn_vld = 1'b1;
        @(posedge clk); #1;
        bus.conn_vld = 1'b0;
        n_cmp++;
        if (err_late !== 1'b1 || bus.out_conn !== mk(1, 7, 8) || bus.out_rank !== '0) begin
            n_err++;
            $display("FAIL late err: err=%b conn=%h rank=%0d, want 1/%h/0",
                     err_late, bus.out_conn, bus.out_rank, mk(1, 7, 8));
        end
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (bus.out_vld !== 1'b1 || bus.out_conn !== mk(2, 5, 6) ||
                bus.out_rank !== CNT_W'(1) || bus.out_last !== 1'b1) begin
                n_err++;
                $display("FAIL stall%0d: vld=%b conn=%h rank=%0d last=%b, want 1/%h/1/1",
                         c, bus.out_vld, bus.out_conn, bus.out_rank, bus.out_last, mk(2, 5, 6));
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (bus.out_vld !== 1'b0 || err_late !== 1'b0 || sort_done !== 1'b0 || bus.out_rank !== '0) begin
            n_err++;
            $display("FAIL midrst: vld=%b err=%b done=%b rank=%0d, want 0/0/0/0",
                     bus.out_vld, err_late, sort_done, bus.out_rank);
        end
        mq.delete();
        send(mk(5, 1, 1));
        bus.done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_vld !== 1'b1 || bus.out_conn !== mk(5, 1, 1) || bus.out_last !== 1'b1) begin
            n_err++;
            $display("FAIL refill: vld=%b conn=%h last=%b, want 1/%h/1",
                     bus.out_vld, bus.out_conn, bus.out_last, mk(5, 1, 1));
        end
    endtask

    task automatic test_random();
        int n, idx, budget;
        logic rdy;
        for (int it = 0; it < 20; it++) begin
            do_reset();
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                send(mk($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255)));
            end
            bus.done = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
`ifdef TOPK_DROP_CNT_EN
            n_cmp++;
            if (drop_cnt !== 32'(m_drops)) begin
                n_err++;
                $display("FAIL rand%0d drop_cnt: got %0d want %0d", it, drop_cnt, m_drops);
            end
`endif
            if (mq.size() == 0) begin
                @(posedge clk); #1;
            end
            idx = 0;
            budget = 0;
            while (mq.size() > 0 && budget < 200) begin
                rdy = 1'($urandom_range(0, 1));
                bus.out_rdy = rdy;
                n_cmp++;
                if (bus.out_vld !== 1'b1 || bus.out_conn !== mq[0] ||
                    bus.out_rank !== CNT_W'(idx) || bus.out_last !== (mq.size() == 1)) begin
                    n_err++;
                    $display("FAIL rand%0d out%0d: vld=%b conn=%h rank=%0d last=%b, want 1/%h/%0d/%b",
                             it, idx, bus.out_vld, bus.out_conn, bus.out_rank, bus.out_last,
                             mq[0], idx, mq.size() == 1);
                end
                @(posedge clk); #1;
                if (rdy) begin
                    void'(mq.pop_front());
                    idx++;
                end
                budget++;
            end
            bus.out_rdy = 1'b0;
            n_cmp++;
            if (sort_done !== 1'b1 || bus.out_vld !== 1'b0 || mq.size() != 0) begin
                n_err++;
                $display("FAIL rand%0d end: sort_done=%b vld=%b left=%0d, want 1/0/0",
                         it, sort_done, bus.out_vld, mq.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.conn = '0;
        bus.conn_vld = 1'b0;
        bus.done = 1'b0;
        bus.out_rdy = 1'b0;
        test_reset();
        test_empty();
        test_sorted();
        test_late_stall_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
